hash_calc: RTL and testbench
============================

Name: hash_calc

Overview:
- Computes a 256-bit average ("mean-threshold") perceptual hash of one 16x16, 8-bit image (256 pixels) for the image-reordering accelerator.
- Captures the pixel buffer and image header on a valid strobe, then computes the mean pixel value over multiple cycles. Each hash bit is the comparison of one pixel against that mean.
- Outputs the hash tagged with the image header/index and a done flag. Feeds the downstream similarity/reordering stage.

Parameters:
- PIX_PER_CYCLE, 16, pixels summed/compared per cycle; must divide 256 (legal: 1,2,4,8,16,32,64,128,256).
- NUM_PIX, 256, pixels per image; fixed, not overridable in practice.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- image_buffer  input  8 x [0:255]  unpacked pixel array; pixel i = image_buffer[i], unsigned.
- image_header  input  16  image identifier, sampled with valid.
- image_buffer_valid  input  1  start strobe; sampled only in IDLE.
- num_images  input  16  batch size, sampled on the first accepted image after reset.
- hash_value  output  256  result; bit i = (image_buffer[i] >= mean).
- image_index_output  output  16  header of the image whose hash is presented.
- hash_calc_done  output  1  level; high when hash_value is valid for the latest image.

Behaviour:
- Reset (reset=0, async): hash_value=0, image_index_output=0, hash_calc_done=0, state=IDLE, sum=0, image count=0, batch size=0.
- States: IDLE, SUM, MEAN, CMP.
- IDLE, valid=1, batch not exhausted:
  - Latch all 256 pixels into an internal copy.
  - Latch image_header; clear sum and the pixel pointer.
  - Clear hash_calc_done; go to SUM.
  - If image count = 0, also latch num_images.
- SUM: each edge adds PIX_PER_CYCLE latched pixels to a 16-bit accumulator (max 65280, no overflow). After 256/PIX_PER_CYCLE edges, go to MEAN.
- MEAN: one edge; mean = sum[15:8] (floor of sum/256); reset the pointer; go to CMP.
- CMP:
  - Each edge writes PIX_PER_CYCLE bits of an internal hash register; bit i = (pixel[i] >= mean), unsigned.
  - After the last group, on the same edge: hash_value <= internal hash, image_index_output <= latched header, hash_calc_done <= 1, image count += 1, state <= IDLE.
- Latency: done rises 1 + 2*(256/PIX_PER_CYCLE) edges after the accepting edge (33 edges at default).
- Outputs hold their last values while busy; hash_calc_done stays high until the next accepted valid.
- Valid during SUM/MEAN/CMP is ignored (no queueing). Inputs need be stable only on the accepting edge.
- Batch:
  - num_images = 0 is treated as 1.
  - Once image count reaches the latched num_images, further valid is ignored until reset.
  - The count is 16-bit, so no wrap occurs within a legal batch.
- Reset asserted mid-operation aborts immediately to the reset state; no partial outputs appear.

Decomposition:
- Shared package hash_pkg holds:
  - NUM_PIX = 256, PIX_W = 8, HASH_W = 256, IDX_W = 16.
  - typedef pixel_t (logic [7:0]).
  - typedef image_t (pixel_t [0:255]).
  - enum hash_state_t {IDLE, SUM, MEAN, CMP}.
- One sub-module is natural: hash_group_cmp, a combinational block for PIX_PER_CYCLE pixels that outputs their partial sum and compare bits against a given mean. It is reused by SUM and CMP.

Test Plan:
- All pixels = 100, header 0x1234, num_images 4 -> done after 33 cycles; hash_value = all ones; image_index_output = 0x1234.
- pixel[i] = i -> sum 32640, mean 127; hash_value[255:127] = 1, hash_value[126:0] = 0.
- pixel[i] = (i odd ? 255 : 0) -> mean 127; hash_value = {128{2'b10}} (odd bits 1).
- pixel[0] = 255, others 0 -> mean 0; hash all ones. Pixel[0] = 0, others 255 -> mean 254; hash = ~1 (bit 0 = 0).
- Valid pulsed again during SUM with a different header -> ignored; outputs reflect the first image only.
- num_images = 1: first image completes; second valid ignored (done stays 1, outputs unchanged). Separately, reset=0 asserted during CMP -> all outputs 0 immediately, and a new valid after release restarts cleanly.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared types and constants for the perceptual-hash block.
package hash_pkg;
  localparam int NUM_PIX = 256;
  localparam int PIX_W   = 8;
  localparam int HASH_W  = 256;
  localparam int IDX_W   = 16;
  localparam int SUM_W   = 16;  // 256 * 255 = 65280 fits without overflow

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [0:NUM_PIX-1] image_t;

  typedef enum logic [1:0] {IDLE, SUM, MEAN, CMP} hash_state_t;

  // A batch size of zero still lets one image through.
  function automatic logic [IDX_W-1:0] batch_size(input logic [IDX_W-1:0] n);
    return (n == '0) ? IDX_W'(1) : n;
  endfunction
endpackage

// File: rtl/hash_calc_if.sv
// Image-in / hash-out bundle between the producer and the hash block.
interface hash_calc_if;
  import hash_pkg::*;

  image_t             image_buffer;
  logic [IDX_W-1:0]   image_header;
  logic               image_buffer_valid;
  logic [IDX_W-1:0]   num_images;
  logic [HASH_W-1:0]  hash_value;
  logic [IDX_W-1:0]   image_index_output;
  logic               hash_calc_done;

  modport master (
    output image_buffer, image_header, image_buffer_valid, num_images,
    input  hash_value, image_index_output, hash_calc_done
  );

  modport slave (
    input  image_buffer, image_header, image_buffer_valid, num_images,
    output hash_value, image_index_output, hash_calc_done
  );
endinterface

// File: rtl/hash_calc_group_cmp.sv
// One pixel group: partial sum for the mean pass, compare bits for the hash pass.
module hash_group_cmp
  import hash_pkg::*;
#(
  parameter int PIX_PER_CYCLE = 16
) (
  input  pixel_t [PIX_PER_CYCLE-1:0] pix,
  input  pixel_t                     mean,
  output logic   [SUM_W-1:0]         psum,
  output logic   [PIX_PER_CYCLE-1:0] ge
);

  // Adder tree and unsigned compares; both passes share the same pixel mux.
  always_comb begin
    psum = '0;
    ge   = '0;
    for (int k = 0; k < PIX_PER_CYCLE; k++) begin
      psum  = psum + SUM_W'(pix[k]);
      ge[k] = (pix[k] >= mean);
    end
  end

endmodule

// File: rtl/hash_calc.sv
// Mean-threshold 256-bit hash of a 16x16 8-bit image, multi-cycle.
module hash_calc
  import hash_pkg::*;
#(
  parameter int PIX_PER_CYCLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  hash_calc_if.slave  bus
);

  localparam int GROUPS = NUM_PIX / PIX_PER_CYCLE;
  localparam int PTR_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [PTR_W-1:0] LAST_GRP = PTR_W'(GROUPS - 1);

  hash_state_t        state_q;
  image_t             img_q;
  logic [IDX_W-1:0]   hdr_q;
  logic [SUM_W-1:0]   sum_q;
  pixel_t             mean_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [HASH_W-1:0]  hash_q;
  logic [HASH_W-1:0]  hash_out_q;
  logic [IDX_W-1:0]   idx_out_q;
  logic               done_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   batch_q;

  pixel_t [PIX_PER_CYCLE-1:0] grp;
  logic   [SUM_W-1:0]         psum;
  logic   [PIX_PER_CYCLE-1:0] ge;
  logic   [HASH_W-1:0]        hash_nxt;
  logic                       accept;

  // Gather the current pixel group and merge its compare bits into the hash.
  always_comb begin
    grp      = '0;
    hash_nxt = hash_q;
    for (int k = 0; k < PIX_PER_CYCLE; k++) begin
      logic [7:0] pi;
      pi           = 8'(int'(ptr_q) * PIX_PER_CYCLE + k);
      grp[k]       = img_q[pi];
      hash_nxt[pi] = ge[k];
    end
  end

  hash_group_cmp #(.PIX_PER_CYCLE(PIX_PER_CYCLE)) u_grp (
    .pix  (grp),
    .mean (mean_q),
    .psum (psum),
    .ge   (ge)
  );

  // First image after reset is always admitted; later ones only while the batch lasts.
  assign accept = bus.image_buffer_valid && ((cnt_q == '0) || (cnt_q < batch_q));

  // Control FSM: capture, sum pass, mean, compare pass, publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      img_q      <= '0;
      hdr_q      <= '0;
      sum_q      <= '0;
      mean_q     <= '0;
      ptr_q      <= '0;
      hash_q     <= '0;
      hash_out_q <= '0;
      idx_out_q  <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      batch_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            img_q   <= bus.image_buffer;
            hdr_q   <= bus.image_header;
            sum_q   <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            if (cnt_q == '0) batch_q <= batch_size(bus.num_images);
            state_q <= SUM;
          end
        end
        SUM: begin
          sum_q <= sum_q + psum;
          if (ptr_q == LAST_GRP) begin
            ptr_q   <= '0;
            state_q <= MEAN;
          end else begin
            ptr_q <= ptr_q + PTR_W'(1);
          end
        end
        MEAN: begin
          mean_q  <= sum_q[15:8];
          ptr_q   <= '0;
          state_q <= CMP;
        end
        CMP: begin
          hash_q <= hash_nxt;
          if (ptr_q == LAST_GRP) begin
            hash_out_q <= hash_nxt;
            idx_out_q  <= hdr_q;
            done_q     <= 1'b1;
            cnt_q      <= cnt_q + IDX_W'(1);
            ptr_q      <= '0;
            state_q    <= IDLE;
          end else begin
            ptr_q <= ptr_q + PTR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hash_value         = hash_out_q;
  assign bus.image_index_output = idx_out_q;
  assign bus.hash_calc_done     = done_q;

endmodule

// File: tb/tb_hash_calc.sv
// Bench for hash_calc: spec vectors, random images vs a reference model, corner sequences.
module tb_hash_calc;
  import hash_pkg::*;

  localparam int LAT = 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_calc_if bus();

  hash_calc #(.PIX_PER_CYCLE(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string         name;
    image_t        img;
    logic [15:0]   hdr;
    logic [255:0]  exp_hash;
  } vec_t;

  vec_t vt [5];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Reference: mean = floor(sum/256), bit i = pixel i >= mean.
  function automatic logic [255:0] ref_hash(input image_t im);
    int s;
    int m;
    logic [255:0] h;
    s = 0;
    for (int i = 0; i < 256; i++) s += int'(im[i]);
    m = s / 256;
    for (int i = 0; i < 256; i++) h[i] = (int'(im[i]) >= m);
    return h;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.image_buffer_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_hash", bus.hash_value, '0);
    chk("reset_idx",  256'(bus.image_index_output), '0);
    chk("reset_done", 256'(bus.hash_calc_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one image for a single edge, then scramble the inputs.
  task automatic start_img(input image_t im, input logic [15:0] hdr, input logic [15:0] num);
    @(negedge clk);
    bus.image_buffer       = im;
    bus.image_header       = hdr;
    bus.num_images         = num;
    bus.image_buffer_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.image_buffer_valid = 1'b0;
    bus.image_header       = 16'($urandom);
    for (int i = 0; i < 256; i++) bus.image_buffer[i] = 8'($urandom);
  endtask

  // Counts edges after the accepting edge until done; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.hash_calc_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  image_t im, ramp, odd, bright0, dark0, flat;
  logic [255:0] h_keep;
  logic [15:0]  hdr;
  int lat;

  initial begin
    bus.image_buffer       = '0;
    bus.image_header       = '0;
    bus.image_buffer_valid = 1'b0;
    bus.num_images         = '0;

    for (int i = 0; i < 256; i++) begin
      flat[i]    = 8'd100;
      ramp[i]    = 8'(i);
      odd[i]     = (i % 2 == 1) ? 8'd255 : 8'd0;
      bright0[i] = (i == 0) ? 8'd255 : 8'd0;
      dark0[i]   = (i == 0) ? 8'd0 : 8'd255;
    end

    vt[0] = '{"flat100",  flat,    16'h1234, {256{1'b1}}};
    vt[1] = '{"ramp",     ramp,    16'h0001, {{129{1'b1}}, {127{1'b0}}}};
    vt[2] = '{"odd255",   odd,     16'h00A5, {128{2'b10}}};
    vt[3] = '{"bright0",  bright0, 16'hFFFF, {256{1'b1}}};
    vt[4] = '{"dark0",    dark0,   16'h8000, ~256'd1};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      start_img(vt[v].img, vt[v].hdr, 16'd4);
      chk({vt[v].name, "_done_clr"}, 256'(bus.hash_calc_done), '0);
      wait_done(lat);
      chk({vt[v].name, "_lat"},  256'(lat), 256'(LAT));
      chk({vt[v].name, "_hash"}, bus.hash_value, vt[v].exp_hash);
      chk({vt[v].name, "_idx"},  256'(bus.image_index_output), 256'(vt[v].hdr));
    end

    // Back-to-back random images in one batch against the model.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      int lo, hi;
      lo = $urandom_range(200, 0);
      hi = $urandom_range(255, lo);
      for (int i = 0; i < 256; i++) im[i] = 8'($urandom_range(hi, lo));
      hdr = 16'($urandom);
      start_img(im, hdr, 16'd20);
      wait_done(lat);
      chk($sformatf("rnd%0d_lat", r),  256'(lat), 256'(LAT));
      chk($sformatf("rnd%0d_hash", r), bus.hash_value, ref_hash(im));
      chk($sformatf("rnd%0d_idx", r),  256'(bus.image_index_output), 256'(hdr));
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_hold", r), 256'(bus.hash_calc_done), 256'(1));
    end

    // Valid during SUM is dropped, not queued.
    do_reset();
    start_img(flat, 16'h1234, 16'd4);
    repeat (5) @(posedge clk);
    start_img(ramp, 16'hBEEF, 16'd4);
    wait_done(lat);
    chk("busy_lat",  256'(lat), 256'(LAT - 6));
    chk("busy_hash", bus.hash_value, {256{1'b1}});
    chk("busy_idx",  256'(bus.image_index_output), 256'(16'h1234));
    repeat (40) @(posedge clk);
    #1;
    chk("busy_noq_done", 256'(bus.hash_calc_done), 256'(1));
    chk("busy_noq_idx",  256'(bus.image_index_output), 256'(16'h1234));

    // Batch of one (and zero, treated as one): second image refused.
    for (int b = 0; b < 2; b++) begin
      do_reset();
      start_img(ramp, 16'h0A0A, (b == 0) ? 16'd1 : 16'd0);
      wait_done(lat);
      h_keep = bus.hash_value;
      chk($sformatf("batch%0d_hash", b), h_keep, {{129{1'b1}}, {127{1'b0}}});
      start_img(odd, 16'h0B0B, 16'd5);
      repeat (40) @(posedge clk);
      #1;
      chk($sformatf("batch%0d_done", b), 256'(bus.hash_calc_done), 256'(1));
      chk($sformatf("batch%0d_keep", b), bus.hash_value, {{129{1'b1}}, {127{1'b0}}});
      chk($sformatf("batch%0d_idx", b),  256'(bus.image_index_output), 256'(16'h0A0A));
    end

    // Reset in the compare pass clears everything at once; restart is clean.
    do_reset();
    start_img(flat, 16'h5555, 16'd3);
    start_img(flat, 16'h6666, 16'd3);
    repeat (25) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_hash", bus.hash_value, '0);
    chk("abort_idx",  256'(bus.image_index_output), '0);
    chk("abort_done", 256'(bus.hash_calc_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    start_img(dark0, 16'h7777, 16'd2);
    wait_done(lat);
    chk("restart_lat",  256'(lat), 256'(LAT));
    chk("restart_hash", bus.hash_value, ~256'd1);
    chk("restart_idx",  256'(bus.image_index_output), 256'(16'h7777));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
